// File: rtl/pipe_ctrl_n.sv
// Parametrised pipeline stall/flush controller with inst/data bus outstanding tracking.
// Define PIPE_PERF_EN to add the perf_stall_cyc / perf_flush_cnt performance counters.
module pipe_ctrl_n #(
  parameter int NSTAGE     = 5,
  parameter int MAX_OUT    = 2,
  parameter int EXC_STAGE  = 3,
  parameter int BR_STAGE   = 1,
  parameter int FWD_STAGES = NSTAGE - 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    inst_req,
  input  logic                    inst_addr_ok,
  input  logic                    inst_data_ok,
  output logic                    inst_req_en,
  output logic                    inst_discard,
  input  logic                    data_req,
  input  logic                    data_addr_ok,
  input  logic                    data_data_ok,
  output logic                    data_req_en,
  input  logic                    wb_data_pend,
  input  logic [NSTAGE-1:0]       stage_busy,
  input  logic                    id_rs_ren,
  input  logic                    id_rt_ren,
  input  logic [4:0]              id_rs,
  input  logic [4:0]              id_rt,
  input  logic [FWD_STAGES-1:0]   prod_wen,
  input  logic [FWD_STAGES-1:0]   prod_late,
  input  logic [5*FWD_STAGES-1:0] prod_wreg,
  input  logic                    exc_flush,
  input  logic                    br_flush,
  output logic [NSTAGE-1:0]       stall,
  output logic [NSTAGE-1:0]       refresh
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]             perf_stall_cyc,
  output logic [31:0]             perf_flush_cnt
`endif
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic [CW-1:0] inst_cnt_reg, inst_cnt_next;
  logic [CW-1:0] inst_drop_reg, inst_drop_next;
  logic [CW-1:0] data_cnt_reg, data_cnt_next;
  logic          inst_inc, inst_dec, data_inc, data_dec;
  logic          flush, drop_nz, if_busy, haz;
  logic [FWD_STAGES-1:0] haz_vec;
  logic [NSTAGE-1:0]     busy, stall_chain;

  assign flush    = exc_flush | br_flush;
  assign drop_nz  = (inst_drop_reg != '0);
  assign inst_inc = inst_req & inst_addr_ok & (inst_cnt_reg < MAX_CNT);
  assign inst_dec = inst_data_ok & (inst_cnt_reg != '0);
  assign data_inc = data_req & data_addr_ok & (data_cnt_reg < MAX_CNT);
  assign data_dec = data_data_ok & (data_cnt_reg != '0);

  assign inst_cnt_next = inst_cnt_reg + CW'(inst_inc) - CW'(inst_dec);
  assign data_cnt_next = data_cnt_reg + CW'(data_inc) - CW'(data_dec);

  // On flush every fetch still in flight after this cycle becomes stale,
  // except a beat returning right now that is not already being dropped.
  always_comb begin
    inst_drop_next = inst_drop_reg;
    if (flush)
      inst_drop_next = inst_cnt_reg + CW'(inst_inc) - CW'(inst_dec & ~drop_nz);
    else if (inst_data_ok && drop_nz)
      inst_drop_next = inst_drop_reg - CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_cnt_reg  <= '0;
      inst_drop_reg <= '0;
      data_cnt_reg  <= '0;
    end else begin
      inst_cnt_reg  <= inst_cnt_next;
      inst_drop_reg <= inst_drop_next;
      data_cnt_reg  <= data_cnt_next;
    end
  end

  assign inst_req_en  = (inst_cnt_reg < MAX_CNT);
  assign data_req_en  = (data_cnt_reg < MAX_CNT);
  assign inst_discard = inst_data_ok & drop_nz;
  assign if_busy      = inst_discard | drop_nz | ~(inst_data_ok | (inst_cnt_reg == '0));

  genvar gi;
  generate
    for (gi = 0; gi < FWD_STAGES; gi++) begin : g_haz
      logic [4:0] wreg;
      assign wreg = prod_wreg[5*gi +: 5];
      assign haz_vec[gi] = prod_wen[gi] & prod_late[gi] & (wreg != 5'd0) &
                           ((id_rs_ren & (id_rs == wreg)) | (id_rt_ren & (id_rt == wreg)));
    end

    for (gi = 0; gi < NSTAGE; gi++) begin : g_busy
      if (gi == 0) begin : g_if
        assign busy[gi] = stage_busy[gi] | if_busy;
      end else if (gi == 1) begin : g_id
        assign busy[gi] = stage_busy[gi] | haz;
      end else if (gi == EXC_STAGE) begin : g_mem
        assign busy[gi] = stage_busy[gi] | (data_req & ~data_addr_ok);
      end else if (gi == NSTAGE - 1) begin : g_wb
        assign busy[gi] = stage_busy[gi] | (wb_data_pend & ~data_data_ok);
      end else begin : g_plain
        assign busy[gi] = stage_busy[gi];
      end
    end
  endgenerate

  assign haz = |haz_vec;

  // A stage holds if it or anything downstream of it is busy.
  always_comb begin
    logic acc;
    acc = 1'b0;
    stall_chain = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc = acc | busy[i];
      stall_chain[i] = acc;
    end
  end

  always_comb begin
    stall = stall_chain;
    if (exc_flush)
      stall[EXC_STAGE:0] = '0;
  end

  always_comb begin
    refresh = '0;
    for (int i = 0; i < NSTAGE - 1; i++)
      refresh[i+1] = stall[i] & ~stall[i+1];
    if (exc_flush)
      refresh[EXC_STAGE:0] = '1;
    else if (br_flush)
      refresh[BR_STAGE-1:0] = '1;
  end

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cyc <= perf_stall_cyc + 32'(stall[1]);
      perf_flush_cnt <= perf_flush_cnt + 32'(flush);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Self-checking bench for pipe_ctrl_n: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipe_ctrl_n;
  localparam int NS  = 5;
  localparam int MO  = 2;
  localparam int EXC = 3;
  localparam int BR  = 1;
  localparam int FW  = NS - 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic inst_req, inst_addr_ok, inst_data_ok, inst_req_en, inst_discard;
  logic data_req, data_addr_ok, data_data_ok, data_req_en;
  logic wb_data_pend;
  logic [NS-1:0] stage_busy;
  logic id_rs_ren, id_rt_ren;
  logic [4:0] id_rs, id_rt;
  logic [FW-1:0] prod_wen, prod_late;
  logic [5*FW-1:0] prod_wreg;
  logic exc_flush, br_flush;
  logic [NS-1:0] stall, refresh;
  logic inst_req_en1, inst_discard1, data_req_en1;
  logic [NS-1:0] stall1, refresh1;
`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_stall_cyc1, perf_flush_cnt1;
`endif

  pipe_ctrl_n #(.NSTAGE(NS), .MAX_OUT(MO), .EXC_STAGE(EXC), .BR_STAGE(BR)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_req_en(inst_req_en), .inst_discard(inst_discard),
    .data_req(data_req), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_req_en(data_req_en), .wb_data_pend(wb_data_pend), .stage_busy(stage_busy),
    .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren), .id_rs(id_rs), .id_rt(id_rt),
    .prod_wen(prod_wen), .prod_late(prod_late), .prod_wreg(prod_wreg),
    .exc_flush(exc_flush), .br_flush(br_flush), .stall(stall), .refresh(refresh)
`ifdef PIPE_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  pipe_ctrl_n #(.NSTAGE(NS), .MAX_OUT(1), .EXC_STAGE(EXC), .BR_STAGE(BR)) dut1 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_req_en(inst_req_en1), .inst_discard(inst_discard1),
    .data_req(data_req), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_req_en(data_req_en1), .wb_data_pend(wb_data_pend), .stage_busy(stage_busy),
    .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren), .id_rs(id_rs), .id_rt(id_rt),
    .prod_wen(prod_wen), .prod_late(prod_late), .prod_wreg(prod_wreg),
    .exc_flush(exc_flush), .br_flush(br_flush), .stall(stall1), .refresh(refresh1)
`ifdef PIPE_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc1), .perf_flush_cnt(perf_flush_cnt1)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: outstanding fetches, stale fetches, outstanding data.
  int m_cnt, m_drop, m_dcnt;
  logic [NS-1:0] e_stall, e_refresh;
  logic e_ireq, e_dreq, e_disc;

  task automatic model_eval();
    bit b[NS];
    bit haz;
    bit any;
    logic [4:0] w;
    haz = 0;
    e_disc = inst_data_ok && (m_drop != 0);
    e_ireq = (m_cnt < MO);
    e_dreq = (m_dcnt < MO);
    for (int k = 0; k < FW; k++) begin
      w = prod_wreg[5*k +: 5];
      if (prod_wen[k] && prod_late[k] && w != 0 &&
          ((id_rs_ren && id_rs == w) || (id_rt_ren && id_rt == w)))
        haz = 1;
    end
    for (int i = 0; i < NS; i++) b[i] = stage_busy[i];
    b[0]    = b[0] || e_disc || (m_drop != 0) || (m_cnt != 0 && !inst_data_ok);
    b[1]    = b[1] || haz;
    b[EXC]  = b[EXC] || (data_req && !data_addr_ok);
    b[NS-1] = b[NS-1] || (wb_data_pend && !data_data_ok);
    for (int i = 0; i < NS; i++) begin
      any = 0;
      for (int j = i; j < NS; j++) any = any || b[j];
      e_stall[i] = any && !(exc_flush && i <= EXC);
    end
    e_refresh = '0;
    for (int i = 1; i < NS; i++) e_refresh[i] = e_stall[i-1] && !e_stall[i];
    for (int i = 0; i < NS; i++) begin
      if (exc_flush && i <= EXC) e_refresh[i] = 1'b1;
      else if (!exc_flush && br_flush && i < BR) e_refresh[i] = 1'b1;
    end
  endtask

  task automatic model_step();
    int acc, c0, d0;
    acc = (inst_req && inst_addr_ok) ? 1 : 0;
    c0 = m_cnt;
    d0 = m_dcnt;
    if (exc_flush || br_flush)
      m_drop = c0 + acc - ((inst_data_ok && m_drop == 0) ? 1 : 0);
    else if (inst_data_ok && m_drop > 0)
      m_drop = m_drop - 1;
    m_cnt  = c0 + ((acc == 1 && c0 < MO) ? 1 : 0) - ((inst_data_ok && c0 > 0) ? 1 : 0);
    m_dcnt = d0 + ((data_req && data_addr_ok && d0 < MO) ? 1 : 0)
                - ((data_data_ok && d0 > 0) ? 1 : 0);
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr_ok = 0; inst_data_ok = 0;
    data_req = 0; data_addr_ok = 0; data_data_ok = 0;
    wb_data_pend = 0; stage_busy = '0;
    id_rs_ren = 0; id_rt_ren = 0; id_rs = '0; id_rt = '0;
    prod_wen = '0; prod_late = '0; prod_wreg = '0;
    exc_flush = 0; br_flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    m_cnt = 0; m_drop = 0; m_dcnt = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++;
    if ({stall, refresh, inst_req_en, data_req_en, inst_discard} !== {10'b0, 3'b110}) n_fail++;
    $display("%s reset_idle: got st=%b rf=%b ie=%b de=%b dc=%b exp st=0 rf=0 ie=1 de=1 dc=0",
             ({stall, refresh, inst_req_en, data_req_en, inst_discard} !== {10'b0, 3'b110}) ? "FAIL" : "pass",
             stall, refresh, inst_req_en, data_req_en, inst_discard);
    next_cycle(); inst_req = 1; inst_addr_ok = 1;
    next_cycle(); inst_req = 1; inst_addr_ok = 1;
    next_cycle();
    @(negedge clk);
    n_chk++;
    if ({inst_req_en, stall, refresh} !== {1'b0, 5'b00001, 5'b00010}) n_fail++;
    $display("%s two_inflight: got ie=%b st=%b rf=%b exp ie=0 st=00001 rf=00010",
             ({inst_req_en, stall, refresh} !== {1'b0, 5'b00001, 5'b00010}) ? "FAIL" : "pass",
             inst_req_en, stall, refresh);
    resetn = 1'b0;
    #1;
    n_chk++;
    if ({inst_req_en, stall, refresh} !== {1'b1, 10'b0}) n_fail++;
    $display("%s async_reset: got ie=%b st=%b rf=%b exp ie=1 st=0 rf=0",
             ({inst_req_en, stall, refresh} !== {1'b1, 10'b0}) ? "FAIL" : "pass",
             inst_req_en, stall, refresh);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({inst_req_en, stall, refresh} !== {1'b1, 10'b0}) n_fail++;
    $display("%s after_reset: got ie=%b st=%b rf=%b exp ie=1 st=0 rf=0",
             ({inst_req_en, stall, refresh} !== {1'b1, 10'b0}) ? "FAIL" : "pass",
             inst_req_en, stall, refresh);
  endtask

  task automatic test_br_flush();
    logic [2:0] exp_disc;
    do_reset();
    inst_req = 1; inst_addr_ok = 1;
    next_cycle(); inst_req = 1; inst_addr_ok = 1;
    next_cycle(); br_flush = 1;
    @(negedge clk);
    n_chk++;
    if (refresh !== 5'b00011) n_fail++;
    $display("%s br_refresh: got %b exp 00011", (refresh !== 5'b00011) ? "FAIL" : "pass", refresh);
    exp_disc = 3'b110;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i == 2) begin
        inst_req = 1; inst_addr_ok = 1;
        next_cycle();
      end
      inst_data_ok = 1;
      @(negedge clk);
      n_chk++;
      if (inst_discard !== exp_disc[2-i]) n_fail++;
      $display("%s discard_beat%0d: got %b exp %b",
               (inst_discard !== exp_disc[2-i]) ? "FAIL" : "pass", i, inst_discard, exp_disc[2-i]);
    end
    n_chk++;
    if (stall !== 5'b00000) n_fail++;
    $display("%s fresh_beat_stall: got %b exp 00000", (stall !== 5'b00000) ? "FAIL" : "pass", stall);
  endtask

  task automatic test_hazard();
    do_reset();
    prod_wen = 2'b01; prod_late = 2'b01; prod_wreg = {5'd0, 5'd5};
    id_rs_ren = 1; id_rs = 5'd5;
    @(negedge clk);
    n_chk++;
    if ({stall, refresh} !== {5'b00011, 5'b00100}) n_fail++;
    $display("%s haz_load: got st=%b rf=%b exp st=00011 rf=00100",
             ({stall, refresh} !== {5'b00011, 5'b00100}) ? "FAIL" : "pass", stall, refresh);
    prod_late = 2'b00;
    #1;
    n_chk++;
    if ({stall, refresh} !== 10'b0) n_fail++;
    $display("%s haz_not_late: got st=%b rf=%b exp 0 0",
             ({stall, refresh} !== 10'b0) ? "FAIL" : "pass", stall, refresh);
    prod_wen = 2'b11; prod_late = 2'b11; prod_wreg = {5'd0, 5'd0};
    id_rs = 5'd0; id_rt_ren = 1; id_rt = 5'd0;
    #1;
    n_chk++;
    if (stall !== 5'b0) n_fail++;
    $display("%s haz_r0: got st=%b exp 00000", (stall !== 5'b0) ? "FAIL" : "pass", stall);
    prod_wreg = {5'd7, 5'd3}; id_rs_ren = 0; id_rt = 5'd7;
    #1;
    n_chk++;
    if (stall !== 5'b00011) n_fail++;
    $display("%s haz_rt_stage3: got st=%b exp 00011", (stall !== 5'b00011) ? "FAIL" : "pass", stall);
  endtask

  task automatic test_data_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      data_req = 1;
      @(negedge clk);
      n_chk++;
      if ({stall, refresh} !== {5'b01111, 5'b10000}) n_fail++;
      $display("%s data_wait%0d: got st=%b rf=%b exp st=01111 rf=10000",
               ({stall, refresh} !== {5'b01111, 5'b10000}) ? "FAIL" : "pass", i, stall, refresh);
      next_cycle();
    end
    data_req = 1; data_addr_ok = 1;
    next_cycle(); data_req = 1; data_addr_ok = 1;
    @(negedge clk);
    n_chk++;
    if ({stall, data_req_en} !== {5'b0, 1'b1}) n_fail++;
    $display("%s data_accept: got st=%b de=%b exp st=0 de=1",
             ({stall, data_req_en} !== {5'b0, 1'b1}) ? "FAIL" : "pass", stall, data_req_en);
    next_cycle(); data_data_ok = 1;
    @(negedge clk);
    n_chk++;
    if (data_req_en !== 1'b0) n_fail++;
    $display("%s data_full: got de=%b exp 0", (data_req_en !== 1'b0) ? "FAIL" : "pass", data_req_en);
    next_cycle();
    @(negedge clk);
    n_chk++;
    if (data_req_en !== 1'b1) n_fail++;
    $display("%s data_drain: got de=%b exp 1", (data_req_en !== 1'b1) ? "FAIL" : "pass", data_req_en);
  endtask

  task automatic test_exc_flush();
    do_reset();
    data_req = 1; data_addr_ok = 1;
    next_cycle(); wb_data_pend = 1; exc_flush = 1; br_flush = 1;
    @(negedge clk);
    n_chk++;
    if ({stall, refresh} !== {5'b10000, 5'b01111}) n_fail++;
    $display("%s exc_flush: got st=%b rf=%b exp st=10000 rf=01111",
             ({stall, refresh} !== {5'b10000, 5'b01111}) ? "FAIL" : "pass", stall, refresh);
    next_cycle(); wb_data_pend = 1; data_req = 1; data_addr_ok = 1;
    @(negedge clk);
    n_chk++;
    if ({stall, data_req_en} !== {5'b11111, 1'b1}) n_fail++;
    $display("%s post_exc: got st=%b de=%b exp st=11111 de=1",
             ({stall, data_req_en} !== {5'b11111, 1'b1}) ? "FAIL" : "pass", stall, data_req_en);
    next_cycle();
    @(negedge clk);
    n_chk++;
    if (data_req_en !== 1'b0) n_fail++;
    $display("%s exc_keeps_dcnt: got de=%b exp 0", (data_req_en !== 1'b0) ? "FAIL" : "pass", data_req_en);
  endtask

  task automatic test_max1();
    logic [3:0] exp_en;
    do_reset();
    exp_en = 4'b0001;
    inst_req = 1; inst_addr_ok = 1;
    @(negedge clk);
    n_chk++;
    if (inst_req_en1 !== 1'b1) n_fail++;
    $display("%s max1_idle: got %b exp 1", (inst_req_en1 !== 1'b1) ? "FAIL" : "pass", inst_req_en1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 2) inst_data_ok = 1;
      @(negedge clk);
      n_chk++;
      if (inst_req_en1 !== exp_en[3-i]) n_fail++;
      $display("%s max1_step%0d: got %b exp %b",
               (inst_req_en1 !== exp_en[3-i]) ? "FAIL" : "pass", i, inst_req_en1, exp_en[3-i]);
    end
  endtask

  task automatic test_random();
    int loc_fail;
    loc_fail = 0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      inst_req     = ($urandom_range(0, 1) == 1);
      inst_addr_ok = (m_cnt < MO) ? ($urandom_range(0, 1) == 1) : 1'b0;
      inst_data_ok = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      data_req     = ($urandom_range(0, 1) == 1);
      data_addr_ok = (m_dcnt < MO) ? ($urandom_range(0, 1) == 1) : 1'b0;
      data_data_ok = (m_dcnt > 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
      wb_data_pend = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NS; i++) stage_busy[i] = ($urandom_range(0, 7) == 0);
      id_rs_ren = ($urandom_range(0, 1) == 1);
      id_rt_ren = ($urandom_range(0, 1) == 1);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      for (int k = 0; k < FW; k++) begin
        prod_wen[k]  = ($urandom_range(0, 1) == 1);
        prod_late[k] = ($urandom_range(0, 1) == 1);
        prod_wreg[5*k +: 5] = 5'($urandom_range(0, 3));
      end
      exc_flush = ($urandom_range(0, 11) == 0);
      br_flush  = ($urandom_range(0, 7) == 0);
      model_eval();
      @(negedge clk);
      n_chk++;
      if ({stall, refresh, inst_req_en, data_req_en, inst_discard} !==
          {e_stall, e_refresh, e_ireq, e_dreq, e_disc}) begin
        n_fail++;
        loc_fail++;
        $display("FAIL rand_cycle%0d: got st=%b rf=%b ie=%b de=%b dc=%b exp st=%b rf=%b ie=%b de=%b dc=%b",
                 n, stall, refresh, inst_req_en, data_req_en, inst_discard,
                 e_stall, e_refresh, e_ireq, e_dreq, e_disc);
      end
      @(posedge clk);
      model_step();
      #1;
    end
    $display("random: 600 cycles, %0d mismatching cycles", loc_fail);
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_br_flush();
    test_hazard();
    test_data_stall();
    test_exc_flush();
    test_max1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_n.md
Name: pipe_ctrl_n

Overview:
- Parametrised pipeline stall/flush controller, successor to the fixed four-segment control unit.
- Generalised to NSTAGE stages with configurable exception and branch-resolve stages.
- Adds registered tracking of outstanding instruction/data bus transactions (up to MAX_OUT each) and discards instruction responses made stale by a flush.
- Sits beside the datapath; drives per-stage stall/refresh vectors and request-enable gates to the inst/data bus interfaces.

Parameters:
- NSTAGE, 5, number of pipeline stages; index 0 = IF, 1 = ID, NSTAGE-1 = WB; legal 4..8
- MAX_OUT, 2, max in-flight requests per bus (addr accepted, data not yet returned); legal 1..7
- EXC_STAGE, 3, stage that raises exceptions/eret; legal 2..NSTAGE-2
- BR_STAGE, 1, stage that resolves branch mispredicts; legal 1..EXC_STAGE-1
- FWD_STAGES, NSTAGE-3, number of producer stages checked for late-result hazards (stages 2..FWD_STAGES+1)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request issued this cycle
- inst_addr_ok  in  1  fetch address accepted
- inst_data_ok  in  1  fetch data returned
- inst_req_en  out  1  fetch may issue a request this cycle
- inst_discard  out  1  returning fetch data is stale; IF must drop it
- data_req  in  1  data request from stage EXC_STAGE
- data_addr_ok  in  1  data address accepted
- data_data_ok  in  1  data returned/write acknowledged
- data_req_en  out  1  data side may issue a request
- wb_data_pend  in  1  WB instruction awaits data
- stage_busy  in  NSTAGE  local multi-cycle hold (div/mul etc.)
- id_rs_ren, id_rt_ren  in  1 each  ID reads rs/rt
- id_rs, id_rt  in  5 each  ID source registers
- prod_wen  in  FWD_STAGES  producer stage writes a register
- prod_late  in  FWD_STAGES  producer result not yet forwardable (load, cp0 read, mul)
- prod_wreg  in  5*FWD_STAGES  flattened destinations; slice k = stage k+2
- exc_flush  in  1  exception or eret committed at EXC_STAGE
- br_flush  in  1  mispredict at BR_STAGE
- stall  out  NSTAGE  hold pipeline register of stage i
- refresh  out  NSTAGE  clear pipeline register of stage i (bubble)

Behaviour:
- Reset (async, resetn=0): inst_cnt=0, inst_drop=0, data_cnt=0; all outputs combinational from these, so stall=0, refresh=0, inst_discard=0, req_en=1 when inputs idle.
- inst_cnt: +1 on inst_req&inst_addr_ok, -1 on inst_data_ok; both in one cycle leaves it unchanged. inst_req_en = inst_cnt<MAX_OUT. data_cnt and data_req_en likewise.
- inst_drop: on exc_flush|br_flush, inst_drop <= inst_cnt + (inst_req&inst_addr_ok) - (inst_data_ok&inst_drop==0). Otherwise decrements on inst_data_ok while nonzero.
- inst_discard = inst_data_ok & inst_drop!=0.
- Flush coinciding with an inst_data_ok when inst_drop==0: that beat is not discarded (it is consumed and flushed by refresh).
- Late hazard: haz = OR over k of prod_wen[k]&prod_late[k]&reg!=0&((id_rs_ren&id_rs==wreg)|(id_rt_ren&id_rt==wreg)). It makes ID busy.
- Stage busy: b[0] = inst_discard | (inst_drop!=0) | !inst_data_ok_or_idle; b[1] |= haz; b[EXC_STAGE] |= data_req&!data_addr_ok; b[NSTAGE-1] |= wb_data_pend&!data_data_ok.
- stall[NSTAGE-1] = b[NSTAGE-1]; stall[i] = b[i] | stall[i+1] for i<NSTAGE-1.
- refresh[i+1] = stall[i] & !stall[i+1] (bubble).
- exc_flush: refresh[i]=1 for i<=EXC_STAGE, stall forced 0 for those stages; stalls of later stages unchanged.
- br_flush: refresh[i]=1 for i<BR_STAGE.
- exc_flush overrides br_flush in the same cycle.
- Data requests are never dropped; data_cnt unaffected by flushes.
- Counters saturate-guarded: increment ignored at MAX_OUT (protocol violation); decrement ignored at 0.

Optional Feature:
- PIPE_PERF_EN defined: adds outputs perf_stall_cyc (32, counts cycles with stall[1]=1) and perf_flush_cnt (32, counts exc_flush|br_flush cycles). Both are cleared by reset and wrap at 2^32.
- Undefined: these ports and counters do not exist.

Test Plan:
- Reset mid-flight with inst_cnt=2 -> next cycle inst_cnt=0, inst_req_en=1, stall=0, refresh=0.
- Two fetches accepted, no data, br_flush -> inst_drop=2. Next two inst_data_ok assert inst_discard; third inst_data_ok has inst_discard=0.
- Stage 2 load writing r5 (prod_late[0]=1), ID reads rs=5 -> stall[1:0]=11, refresh[2]=1. Same with prod_late=0 -> no stall.
- data_req with addr_ok low 3 cycles, NSTAGE=5 -> stall[3:0]=1111 for 3 cycles, refresh[4]=1.
- exc_flush while WB waits on data_data_ok -> refresh[3:0]=1111, stall[4]=1, data_cnt unchanged.
- MAX_OUT=1: one accepted fetch -> inst_req_en=0 until inst_data_ok, then 1.
